// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// rtl/bsg_manycore_link_to_axil_pkg.sv - shared address map and response codes for the manycore-link-to-AXIL bridge
package bsg_manycore_link_to_axil_pkg;

  // Each slot owns a 2^base_w_gp byte window starting at slot_base_addr_gp.
  localparam int base_w_gp = 6;
  localparam int slot_w_gp = 8;
  localparam logic [31:0] slot_base_addr_gp = 32'h0000_1000;

  localparam logic [base_w_gp-1:0] ofs_isr_gp  = 6'h00;
  localparam logic [base_w_gp-1:0] ofs_tdfv_gp = 6'h0C;
  localparam logic [base_w_gp-1:0] ofs_rdfo_gp = 6'h1C;
  localparam logic [base_w_gp-1:0] ofs_rdr_gp  = 6'h20;

  localparam logic [1:0] resp_okay_gp   = 2'b00;
  localparam logic [1:0] resp_slverr_gp = 2'b10;
  localparam logic [1:0] resp_decerr_gp = 2'b11;

  function automatic logic [31:0] slot_addr(input int slot, input logic [base_w_gp-1:0] ofs);
    return slot_base_addr_gp + (32'(slot) << base_w_gp) + 32'(ofs);
  endfunction

endpackage

// File: rtl/bsg_axil_rxs.sv
// rtl/bsg_axil_rxs.sv - AXI-Lite read-channel slave serving per-slot rx FIFO, ISR, RDFO and TDFV reads
module bsg_axil_rxs
  import bsg_manycore_link_to_axil_pkg::*;
#(
  parameter int num_fifos_p = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [31:0]                 araddr_i,
  input  logic                        arvalid_i,
  output logic                        arready_o,
  output logic [31:0]                 rdata_o,
  output logic [1:0]                  rresp_o,
  output logic                        rvalid_o,
  input  logic                        rready_i,
  input  logic [num_fifos_p-1:0][31:0] rxs_i,
  input  logic [num_fifos_p-1:0]      rxs_v_i,
  output logic [num_fifos_p-1:0]      rxs_yumi_o,
  input  logic [num_fifos_p-1:0][31:0] isrs_i,
  input  logic [num_fifos_p-1:0][31:0] rdfo_i,
  input  logic [num_fifos_p-1:0][31:0] tdfv_i
);

  localparam logic [1:0] idle_s = 2'd0;
  localparam logic [1:0] addr_s = 2'd1;
  localparam logic [1:0] data_s = 2'd2;
  localparam logic [1:0] resp_s = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] ar_q;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      idle_s: if (arvalid_i) state_d = addr_s;
      addr_s: if (arvalid_i) state_d = data_s;
      data_s: state_d = resp_s;
      resp_s: if (rready_i) state_d = idle_s;
      default: state_d = idle_s;
    endcase
  end

  logic [base_w_gp-1:0] ofs;
  logic                 is_rdr, is_isr, is_rdfo, is_tdfv;
  logic                 unused_addr_bits;

  assign ofs     = ar_q[base_w_gp-1:0];
  assign is_rdr  = (ofs == ofs_rdr_gp);
  assign is_isr  = (ofs == ofs_isr_gp);
  assign is_rdfo = (ofs == ofs_rdfo_gp);
  assign is_tdfv = (ofs == ofs_tdfv_gp);
  assign unused_addr_bits = ^ar_q[31:base_w_gp+slot_w_gp];

  logic [num_fifos_p-1:0]       slot_hit;
  logic [num_fifos_p-1:0]       slot_empty_rdr;
  logic [num_fifos_p-1:0][31:0] slot_word;

  // Slot ids are distinct, so slot_hit is one-hot and the AND-OR mux below is exact.
  for (genvar i = 0; i < num_fifos_p; i++) begin : g_slot
    localparam logic [slot_w_gp-1:0] slot_id_lp =
      slot_w_gp'(slot_base_addr_gp >> base_w_gp) + slot_w_gp'(i);

    assign slot_hit[i]       = (ar_q[base_w_gp +: slot_w_gp] == slot_id_lp);
    assign slot_empty_rdr[i] = slot_hit[i] & is_rdr & ~rxs_v_i[i];
    assign slot_word[i]      = {32{slot_hit[i]}} &
                               (({32{is_rdr & rxs_v_i[i]}} & rxs_i[i])
                              | ({32{is_isr}}             & isrs_i[i])
                              | ({32{is_rdfo}}            & rdfo_i[i])
                              | ({32{is_tdfv}}            & tdfv_i[i]));
    // Pop is combinational in DATA and suppressed while reset is asserted.
    assign rxs_yumi_o[i]     = (state_q == data_s) & ~reset_i & slot_hit[i] & is_rdr & rxs_v_i[i];
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < num_fifos_p; i++) rdata_d = rdata_d | slot_word[i];
  end

  always_comb begin
    rresp_d = resp_okay_gp;
    if (~|slot_hit)           rresp_d = resp_decerr_gp;
    else if (|slot_empty_rdr) rresp_d = resp_slverr_gp;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= idle_s;
      ar_q    <= '0;
      rdata_q <= '0;
      rresp_q <= resp_okay_gp;
    end else begin
      state_q <= state_d;
      if (state_q == addr_s && arvalid_i) ar_q <= araddr_i;
      if (state_q == data_s) begin
        rdata_q <= rdata_d;
        rresp_q <= rresp_d;
      end
    end
  end

  assign arready_o = (state_q == addr_s);
  assign rvalid_o  = (state_q == resp_s);
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;

endmodule

// File: tb/tb_bsg_axil_rxs.sv
// tb/tb_bsg_axil_rxs.sv - table-driven self-checking bench for bsg_axil_rxs
module tb_bsg_axil_rxs;
  import bsg_manycore_link_to_axil_pkg::*;

  localparam int n = 2;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] araddr;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [n-1:0][31:0] rxs, isrs, rdfo, tdfv;
  logic [n-1:0] rxs_v, yumi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_axil_rxs #(.num_fifos_p(n)) dut (
    .clk_i(clk), .reset_i(reset),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .rxs_i(rxs), .rxs_v_i(rxs_v), .rxs_yumi_o(yumi),
    .isrs_i(isrs), .rdfo_i(rdfo), .tdfv_i(tdfv)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [1:0]  rv;
    logic [31:0] rx0, rx1, isr1, rdfo1, tdfv1;
    int          hold;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    int          exp_p0, exp_p1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int hold,
                         output logic [31:0] d, output logic [1:0] r,
                         output int p0, output int p1, output int ar_lat,
                         output int lat, output int stable_ok);
    bit got, ar_seen;
    p0 = 0; p1 = 0; lat = -1; ar_lat = -1; d = '0; r = '0; stable_ok = 1;
    got = 0; ar_seen = 0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    for (int k = 1; k <= 30 && !got; k++) begin
      @(negedge clk);
      p0 += int'(yumi[0]); p1 += int'(yumi[1]);
      if (ar_seen) arvalid = 1'b0;
      if (arready && !ar_seen) begin ar_seen = 1; ar_lat = k; end
      if (rvalid) begin lat = k; d = rdata; r = rresp; got = 1; end
    end
    arvalid = 1'b0;
    if (got) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        p0 += int'(yumi[0]); p1 += int'(yumi[1]);
        if (!rvalid || rdata !== d || rresp !== r) stable_ok = 0;
      end
      rready = 1'b1;
      @(negedge clk);
      p0 += int'(yumi[0]); p1 += int'(yumi[1]);
      if (rvalid) stable_ok = 0;
      rready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int p0, p1, ar_lat, lat, st;

    reset = 1'b1; arvalid = 1'b0; rready = 1'b0; araddr = '0;
    rxs = '0; rxs_v = '0;
    isrs[0] = 32'hA5A5_0000; rdfo[0] = 32'd3; tdfv[0] = 32'd9;
    isrs[1] = '0; rdfo[1] = '0; tdfv[1] = '0;

    vecs.push_back('{"rdr0_hit",   32'h0000_1020, 2'b01, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'hDEADBEEF, 2'b00, 1, 0});
    vecs.push_back('{"rdr1_empty", 32'h0000_1060, 2'b01, 32'h1111_2222, 32'h3333_4444, 32'h0, 32'h0, 32'h0, 0, 32'h0, 2'b10, 0, 0});
    vecs.push_back('{"no_slot",    32'h0000_0020, 2'b11, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0, 0, 32'h0, 2'b11, 0, 0});
    vecs.push_back('{"past_last",  32'h0000_10A0, 2'b11, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0, 0, 32'h0, 2'b11, 0, 0});
    vecs.push_back('{"rdfo1",      32'h0000_105C, 2'b00, 32'h0, 32'h0, 32'h0800_0000, 32'd5, 32'd7, 0, 32'd5, 2'b00, 0, 0});
    vecs.push_back('{"tdfv1",      32'h0000_104C, 2'b00, 32'h0, 32'h0, 32'h0800_0000, 32'd5, 32'd7, 0, 32'd7, 2'b00, 0, 0});
    vecs.push_back('{"isr1",       32'h0000_1040, 2'b00, 32'h0, 32'h0, 32'h0800_0000, 32'd5, 32'd7, 0, 32'h0800_0000, 2'b00, 0, 0});
    vecs.push_back('{"other_ofs1", 32'h0000_1044, 2'b11, 32'h5, 32'h6, 32'h0800_0000, 32'd5, 32'd7, 0, 32'h0, 2'b00, 0, 0});
    vecs.push_back('{"isr0",       32'h0000_1000, 2'b11, 32'h5, 32'h6, 32'h0, 32'h0, 32'h0, 0, 32'hA5A5_0000, 2'b00, 0, 0});
    vecs.push_back('{"rdr1_hold",  32'h0000_1060, 2'b10, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 4, 32'hCAFE_F00D, 2'b00, 0, 1});
    vecs.push_back('{"rdr0_alias_hi", 32'h8000_1020, 2'b01, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h1234_5678, 2'b00, 1, 0});

    repeat (3) @(negedge clk);
    chk("reset_arready", 32'(arready), 32'h0);
    chk("reset_rvalid",  32'(rvalid),  32'h0);
    chk("reset_rdata",   rdata,        32'h0);
    chk("reset_rresp",   32'(rresp),   32'h0);
    chk("reset_yumi",    32'(yumi),    32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      rxs_v = vecs[i].rv; rxs[0] = vecs[i].rx0; rxs[1] = vecs[i].rx1;
      isrs[1] = vecs[i].isr1; rdfo[1] = vecs[i].rdfo1; tdfv[1] = vecs[i].tdfv1;
      do_read(vecs[i].addr, vecs[i].hold, d, r, p0, p1, ar_lat, lat, st);
      chk({vecs[i].name, "_rdata"},  d,           vecs[i].exp_d);
      chk({vecs[i].name, "_rresp"},  32'(r),      32'(vecs[i].exp_r));
      chk({vecs[i].name, "_pop0"},   32'(p0),     32'(vecs[i].exp_p0));
      chk({vecs[i].name, "_pop1"},   32'(p1),     32'(vecs[i].exp_p1));
      chk({vecs[i].name, "_arlat"},  32'(ar_lat), 32'd1);
      chk({vecs[i].name, "_rlat"},   32'(lat),    32'd3);
      chk({vecs[i].name, "_stable"}, 32'(st),     32'd1);
    end

    // Reset asserted during DATA aborts the read with no pop and no response.
    rxs_v = 2'b01; rxs[0] = 32'hDEADBEEF;
    @(negedge clk); araddr = slot_addr(0, ofs_rdr_gp); arvalid = 1'b1;
    @(negedge clk); chk("rst_mid_arready", 32'(arready), 32'h1);
    @(negedge clk); arvalid = 1'b0; reset = 1'b1;
    #1 chk("rst_mid_yumi", 32'(yumi), 32'h0);
    @(negedge clk); reset = 1'b0;
    chk("rst_mid_rvalid", 32'(rvalid), 32'h0);
    chk("rst_mid_arready_idle", 32'(arready), 32'h0);
    p0 = 0; lat = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      p0 += int'(yumi[0]); lat += int'(rvalid);
    end
    chk("rst_mid_no_pop_after", 32'(p0), 32'h0);
    chk("rst_mid_no_resp_after", 32'(lat), 32'h0);
    do_read(slot_addr(0, ofs_rdr_gp), 0, d, r, p0, p1, ar_lat, lat, st);
    chk("post_rst_rdata", d, 32'hDEADBEEF);
    chk("post_rst_rresp", 32'(r), 32'h0);
    chk("post_rst_pop0", 32'(p0), 32'd1);
    chk("post_rst_rlat", 32'(lat), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
